// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - Johnson code types and helpers shared by RTL and counter benches.
package johnson_pkg;

  localparam int JOHNSON_MAX_W = 32;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } johnson_state_t;

  typedef logic [JOHNSON_MAX_W-1:0] johnson_code_t;

  function automatic johnson_code_t johnson_mask(input int width);
    johnson_code_t m;
    m = '0;
    for (int i = 0; i < JOHNSON_MAX_W; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic johnson_code_t johnson_next(input johnson_code_t code, input int width);
    johnson_code_t nxt;
    logic          fb;
    fb     = ~code[width-1];
    nxt    = code << 1;
    nxt[0] = fb;
    return nxt & johnson_mask(width);
  endfunction

  // MSB clear: ones are filling from the bottom; MSB set: zeros are filling from the bottom.
  function automatic int johnson_idx(input johnson_code_t code, input int width);
    int pc;
    pc = 0;
    for (int i = 0; i < JOHNSON_MAX_W; i++) begin
      if (i < width) pc += int'(code[i]);
    end
    return code[width-1] ? (2 * width - pc) : pc;
  endfunction

  function automatic logic johnson_legal(input johnson_code_t code, input int width);
    johnson_code_t mask;
    johnson_code_t masked;
    johnson_code_t low;
    logic          ok;
    mask   = johnson_mask(width);
    masked = code & mask;
    low    = '0;
    ok     = (masked == '0);
    for (int k = 0; k < JOHNSON_MAX_W; k++) begin
      low[k] = 1'b1;
      if (k < width) begin
        if ((masked == low) || (masked == (mask & ~low))) ok = 1'b1;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/johnson_seq_decoder_decode.sv
// rtl/johnson_seq_decoder_decode.sv - combinational legality check and step index of a Johnson code.
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code_i,
  output logic             legal_o,
  output logic [IDX_W-1:0] idx_o
);

  johnson_code_t code_ext;

  assign code_ext = JOHNSON_MAX_W'(code_i);

  always_comb begin
    legal_o = johnson_legal(code_ext, WIDTH);
    idx_o   = IDX_W'(johnson_idx(code_ext, WIDTH));
  end

endmodule

// File: rtl/johnson_seq_decoder.sv
// rtl/johnson_seq_decoder.sv - Johnson code receiver: decode, sequence lock FSM, error counting.
module johnson_seq_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_CNT   = 2,
  parameter int ERR_W      = 8,
  parameter int ALLOW_HOLD = 1,
  localparam int IDX_W     = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] code_in,
  input  logic             in_valid,
  output logic [IDX_W-1:0] idx_out,
  output logic             idx_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             wrap,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int                STEP_W    = $clog2(LOCK_CNT + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LOCK_CNT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(2 * WIDTH - 1);
  localparam bit                HOLD_OK   = (ALLOW_HOLD != 0);

  johnson_state_t    state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              have_q, have_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              idx_valid_q, idx_valid_d;
  logic              illegal_q, illegal_d;
  logic              seq_err_q, seq_err_d;
  logic              wrap_q, wrap_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic              dec_legal;
  logic [IDX_W-1:0]  dec_idx;
  logic [IDX_W-1:0]  idx_succ;
  logic              is_succ;
  logic              is_hold;

  johnson_code_decode #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_decode (
    .code_i  (code_in),
    .legal_o (dec_legal),
    .idx_o   (dec_idx)
  );

  // have_q distinguishes "no predecessor yet" so the first code after reset is never judged.
  assign idx_succ = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
  assign is_succ  = have_q && (dec_idx == idx_succ);
  assign is_hold  = have_q && (dec_idx == idx_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    have_d      = have_q;
    step_d      = step_q;
    idx_valid_d = 1'b0;
    illegal_d   = 1'b0;
    seq_err_d   = 1'b0;
    wrap_d      = 1'b0;
    err_d       = err_q;

    if (in_valid) begin
      if (!dec_legal) begin
        illegal_d = 1'b1;
        step_d    = '0;
        if (state_q == LOCKED) begin
          seq_err_d = 1'b1;
          state_d   = HUNT;
        end
      end else begin
        idx_valid_d = 1'b1;
        idx_d       = dec_idx;
        have_d      = 1'b1;
        case (state_q)
          HUNT: begin
            if (is_succ) begin
              if (step_q == STEP_LAST) begin
                state_d = LOCKED;
                step_d  = '0;
              end else begin
                step_d = step_q + STEP_W'(1);
              end
            end else if (!(is_hold && HOLD_OK)) begin
              step_d = '0;
            end
          end
          LOCKED: begin
            if (is_succ) begin
              wrap_d = (idx_q == IDX_LAST);
            end else if (!(is_hold && HOLD_OK)) begin
              seq_err_d = 1'b1;
              state_d   = HUNT;
              step_d    = '0;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end

    if ((illegal_d || seq_err_d) && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      idx_q       <= '0;
      have_q      <= 1'b0;
      step_q      <= '0;
      idx_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      have_q      <= have_d;
      step_q      <= step_d;
      idx_valid_q <= idx_valid_d;
      illegal_q   <= illegal_d;
      seq_err_q   <= seq_err_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
    end
  end

  assign idx_out   = idx_q;
  assign idx_valid = idx_valid_q;
  assign illegal   = illegal_q;
  assign seq_err   = seq_err_q;
  assign wrap      = wrap_q;
  assign locked    = (state_q == LOCKED);
  assign err_count = err_q;

endmodule

// File: tb/tb_johnson_seq_decoder.sv
// tb/tb_johnson_seq_decoder.sv - bench for johnson_seq_decoder (hold-tolerant and hold-strict instances).
module tb_johnson_seq_decoder;

  localparam int W    = 4;
  localparam int N    = 2 * W;
  localparam int LOCK = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] code_in;

  logic [2:0] a_idx, b_idx;
  logic       a_iv, a_il, a_se, a_wr, a_lk;
  logic       b_iv, b_il, b_se, b_wr, b_lk;
  logic [7:0] a_err;
  logic [1:0] b_err;

  logic [15:0] a_out, b_out;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int prev;
    int run;
    bit lk;
    int errc;
    int idxo;
  } mstate_t;

  typedef struct {
    bit          inv;
    logic [3:0]  code;
    logic [15:0] exp;
  } vec_t;

  mstate_t ms[2];
  bit      cfg_allow[2] = '{1'b1, 1'b0};
  int      cfg_max[2]   = '{255, 3};

  johnson_seq_decoder #(
    .WIDTH(W), .LOCK_CNT(LOCK), .ERR_W(8), .ALLOW_HOLD(1)
  ) u_a (
    .clk(clk), .reset(reset), .code_in(code_in), .in_valid(in_valid),
    .idx_out(a_idx), .idx_valid(a_iv), .illegal(a_il), .seq_err(a_se),
    .wrap(a_wr), .locked(a_lk), .err_count(a_err)
  );

  johnson_seq_decoder #(
    .WIDTH(W), .LOCK_CNT(LOCK), .ERR_W(2), .ALLOW_HOLD(0)
  ) u_b (
    .clk(clk), .reset(reset), .code_in(code_in), .in_valid(in_valid),
    .idx_out(b_idx), .idx_valid(b_iv), .illegal(b_il), .seq_err(b_se),
    .wrap(b_wr), .locked(b_lk), .err_count(b_err)
  );

  assign a_out = {a_idx, a_iv, a_il, a_se, a_wr, a_lk, a_err};
  assign b_out = {b_idx, b_iv, b_il, b_se, b_wr, b_lk, 6'd0, b_err};

  initial forever #5 clk = ~clk;

  // Step k of the ring: k low ones for k<=W, then ones receding from the bottom.
  function automatic logic [3:0] seq_code(input int k);
    if (k <= W) return 4'((1 << k) - 1);
    return 4'(15 ^ ((1 << (k - W)) - 1));
  endfunction

  function automatic int seq_idx(input logic [3:0] c);
    for (int k = 0; k < N; k++) begin
      if (seq_code(k) == c) return k;
    end
    return -1;
  endfunction

  function automatic logic [15:0] mk(input int idx, input bit iv, input bit il,
                                     input bit se, input bit wr, input bit lk, input int err);
    return {3'(idx), iv, il, se, wr, lk, 8'(err)};
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      ms[u].prev = -1;
      ms[u].run  = 0;
      ms[u].lk   = 1'b0;
      ms[u].errc = 0;
      ms[u].idxo = 0;
    end
  endtask

  task automatic model_step(input int u, input bit inv, input logic [3:0] code,
                            output logic [15:0] e);
    bit iv = 0, il = 0, se = 0, wr = 0;
    int n;
    bit succ, hold;
    if (inv) begin
      n = seq_idx(code);
      if (n < 0) begin
        il = 1;
        ms[u].run = 0;
        if (ms[u].lk) begin
          se = 1;
          ms[u].lk = 0;
        end
      end else begin
        iv   = 1;
        succ = (ms[u].prev >= 0) && (n == (ms[u].prev + 1) % N);
        hold = (ms[u].prev >= 0) && (n == ms[u].prev);
        if (ms[u].lk) begin
          if (succ) wr = (ms[u].prev == N - 1);
          else if (!(hold && cfg_allow[u])) begin
            se = 1;
            ms[u].lk  = 0;
            ms[u].run = 0;
          end
        end else begin
          if (succ) begin
            ms[u].run++;
            if (ms[u].run == LOCK) begin
              ms[u].lk  = 1;
              ms[u].run = 0;
            end
          end else if (!(hold && cfg_allow[u])) begin
            ms[u].run = 0;
          end
        end
        ms[u].prev = n;
        ms[u].idxo = n;
      end
      if ((il || se) && ms[u].errc < cfg_max[u]) ms[u].errc++;
    end
    e = mk(ms[u].idxo, iv, il, se, wr, ms[u].lk, ms[u].errc);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply_step(input bit inv, input logic [3:0] code,
                            output logic [15:0] ea, output logic [15:0] eb);
    @(negedge clk);
    in_valid = inv;
    code_in  = code;
    @(posedge clk);
    #1;
    model_step(0, inv, code, ea);
    model_step(1, inv, code, eb);
  endtask

  initial begin
    vec_t        tbl[$];
    logic [3:0]  c;
    logic [15:0] ea, eb;
    int          sat_exp[5] = '{1, 2, 3, 3, 3};
    int          ci;
    bit          inv;
    logic [3:0]  code;

    reset = 1'b1;
    in_valid = 1'b0;
    code_in = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset A", a_out, 16'h0);
    check("reset B", b_out, 16'h0);
    @(negedge clk);
    reset = 1'b0;

    // Counter walk: 20 steps through the ring, lock after the third code, wrap on 7->0.
    c = 4'd0;
    for (int k = 0; k < 20; k++) begin
      tbl.push_back('{1'b1, c, mk(k % N, 1, 0, 0, (k > 0) && (k % N == 0), k >= 2, 0)});
      c = {c[2:0], ~c[3]};
    end
    tbl.push_back('{1'b1, 4'b0101, mk(3, 0, 1, 1, 0, 0, 1)});
    tbl.push_back('{1'b1, 4'b0000, mk(0, 1, 0, 0, 0, 0, 1)});
    tbl.push_back('{1'b1, 4'b0001, mk(1, 1, 0, 0, 0, 0, 1)});
    tbl.push_back('{1'b1, 4'b0011, mk(2, 1, 0, 0, 0, 1, 1)});
    tbl.push_back('{1'b1, 4'b0111, mk(3, 1, 0, 0, 0, 1, 1)});
    tbl.push_back('{1'b1, 4'b1100, mk(6, 1, 0, 1, 0, 0, 2)});
    tbl.push_back('{1'b1, 4'b1000, mk(7, 1, 0, 0, 0, 0, 2)});
    tbl.push_back('{1'b1, 4'b0000, mk(0, 1, 0, 0, 0, 1, 2)});
    tbl.push_back('{1'b1, 4'b0001, mk(1, 1, 0, 0, 0, 1, 2)});
    tbl.push_back('{1'b1, 4'b0011, mk(2, 1, 0, 0, 0, 1, 2)});
    tbl.push_back('{1'b1, 4'b0011, mk(2, 1, 0, 0, 0, 1, 2)});
    tbl.push_back('{1'b1, 4'b0011, mk(2, 1, 0, 0, 0, 1, 2)});
    tbl.push_back('{1'b1, 4'b0111, mk(3, 1, 0, 0, 0, 1, 2)});
    tbl.push_back('{1'b0, 4'b0101, mk(3, 0, 0, 0, 0, 1, 2)});
    tbl.push_back('{1'b0, 4'b1111, mk(3, 0, 0, 0, 0, 1, 2)});

    for (int i = 0; i < tbl.size(); i++) begin
      apply_step(tbl[i].inv, tbl[i].code, ea, eb);
      check($sformatf("tbl[%0d] A", i), a_out, tbl[i].exp);
      check($sformatf("tbl[%0d] B", i), b_out, eb);
    end

    // Asynchronous reset while locked, asserted between clock edges.
    #2;
    reset = 1'b1;
    #1;
    check("async reset A", a_out, 16'h0);
    check("async reset B", b_out, 16'h0);
    model_reset();
    @(posedge clk);
    #1;
    check("reset held A", a_out, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    apply_step(1'b0, 4'b0001, ea, eb);
    check("gap after reset A", a_out, ea);
    check("gap after reset B", b_out, eb);

    // Error counter saturation on the 2-bit instance.
    for (int i = 0; i < 5; i++) begin
      apply_step(1'b1, 4'b0101, ea, eb);
      check($sformatf("sat[%0d] B err", i), 16'(b_err), 16'(sat_exp[i]));
      check($sformatf("sat[%0d] A", i), a_out, ea);
      check($sformatf("sat[%0d] B", i), b_out, eb);
    end

    // Random walk with holds, jumps, garbage codes and valid gaps.
    ci = 0;
    for (int i = 0; i < 400; i++) begin
      int p;
      inv = ($urandom_range(0, 99) < 85);
      p = $urandom_range(0, 99);
      if (p < 70) begin
        ci = (ci + 1) % N;
        code = seq_code(ci);
      end else if (p < 80) begin
        code = seq_code(ci);
      end else if (p < 90) begin
        ci = $urandom_range(0, N - 1);
        code = seq_code(ci);
      end else begin
        code = 4'($urandom);
      end
      apply_step(inv, code, ea, eb);
      check($sformatf("rnd[%0d] A", i), a_out, ea);
      check($sformatf("rnd[%0d] B", i), b_out, eb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
